// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// ----------------------------------------------------------------------------
// Sequential control core of the multicycle CPU. Holds the 3-bit stage
// register and the latched instruction opcode, sequences each instruction
// through its stages and drives the per-stage datapath write enables.
// It also keeps a sticky halt flag, waits in MEM on the data-memory
// handshake and counts retired instructions (saturating).
//
// Optional feature (compile-time macro): MEM_TIMEOUT_EN
//   Defined   : consecutive MEM cycles with mem_ready=0 are counted; on the
//               TIMEOUT-th waiting cycle mem_err pulses for one cycle and the
//               instruction is abandoned (back to IF, no retire, no write).
//   Undefined : MEM waits indefinitely, mem_err is constant 0.
//
// Parameters:
//   CNT_W    width of the retired-instruction counter (saturates at all-ones)
//   TIMEOUT  MEM wait-cycle limit, only meaningful with MEM_TIMEOUT_EN
//
// Ports:
//   CLK          in   system clock, all state updates on the rising edge
//   RST          in   synchronous active-low reset
//   op_in[5:0]   in   opcode from instruction memory, valid during IF
//   mem_ready    in   data-memory completion, only looked at in MEM
//   state[2:0]   out  current stage encoding (also the FSM debug view)
//   opcode[5:0]  out  latched opcode (IR[31:26])
//   PCWre        out  PC write enable (high in the retiring cycle)
//   IRWre        out  instruction register write enable
//   RegWre       out  register file write enable
//   DataMemRW    out  1 = data memory write strobe (sw), 0 = read
//   halted       out  sticky halt indication
//   mem_err      out  MEM timeout pulse
//   instr_count  out  retired instruction count
//
// Handshake: in MEM the stage completes on a cycle where mem_ready=1; while
// mem_ready=0 the FSM holds in MEM. mem_ready is ignored in every other stage
// and DataMemRW is asserted only on the completing cycle of a sw, so memory
// sees exactly one write strobe per store.
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       op_in,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic [5:0]       opcode,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic             DataMemRW,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    // ------------------------------------------------------------------
    // Stage encoding (fixed, shared with the rest of the CPU)
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE3 = 3'b101,
        S_EXE4 = 3'b110,
        S_EXE5 = 3'b010,
        S_MEM  = 3'b011,
        S_WB4  = 3'b111,
        S_WB5  = 3'b100
    } state_e;

    // Opcodes that influence sequencing or enables
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Parameter sanity, evaluated at elaboration
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multicycle_ctrl: CNT_W must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("multicycle_ctrl: TIMEOUT must be at least 1");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Per-cycle decisions from the next-state logic
    logic retire;       // this cycle returns to IF with a completed instruction
    logic set_halt;     // the halt instruction is completing in ID
    logic tmo_abort;    // MEM wait limit reached this cycle

`ifdef MEM_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_wait;

    // tmo_q holds the number of waiting MEM cycles already seen, so the
    // TIMEOUT-th waiting cycle is the one where tmo_q == TIMEOUT-1.
    assign mem_wait  = (state_q == S_MEM) && !mem_ready;
    assign tmo_abort = mem_wait && (tmo_q == TMO_LAST);

    // Counts only while waiting in MEM; any exit from MEM (completion or
    // abort) brings it back to zero for the next memory instruction.
    always_comb begin
        tmo_d = '0;
        if (mem_wait && !tmo_abort) begin
            tmo_d = tmo_q + TW'(1);
        end
    end
`else
    assign tmo_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        set_halt = 1'b0;

        unique case (state_q)
            S_IF: begin
                // Once halted the core parks here until reset.
                if (!halted_q) begin
                    state_d = S_ID;
                end
            end

            S_ID: begin
                unique case (opcode_q)
                    OP_J, OP_JAL, OP_JR: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                    OP_HALT: begin
                        state_d  = S_IF;
                        retire   = 1'b1;
                        set_halt = 1'b1;
                    end
                    OP_BEQ: begin
                        state_d = S_EXE3;
                    end
                    OP_SW, OP_LW: begin
                        state_d = S_EXE5;
                    end
                    default: begin
                        state_d = S_EXE4;
                    end
                endcase
            end

            S_EXE3: begin
                state_d = S_IF;
                retire  = 1'b1;
            end

            S_EXE4: begin
                state_d = S_WB4;
            end

            S_EXE5: begin
                state_d = S_MEM;
            end

            S_MEM: begin
                if (mem_ready) begin
                    if (opcode_q == OP_LW) begin
                        state_d = S_WB5;
                    end else begin
                        // Store completes here; nothing left to write back.
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                end else if (tmo_abort) begin
                    // Abandon the access: no retire, no write strobe.
                    state_d = S_IF;
                end
            end

            S_WB4, S_WB5: begin
                state_d = S_IF;
                retire  = 1'b1;
            end

            default: begin
                // Unreachable with a 3-bit fully-used encoding; recover to
                // IF without retiring anything.
                state_d = S_IF;
            end
        endcase

        // A halted core never retires again. halted_q can only be set while
        // sitting in IF, so this only matters as a guard.
        if (halted_q) begin
            retire   = 1'b0;
            set_halt = 1'b0;
        end
    end

    // Opcode is captured only on a live IF cycle; it is held otherwise so
    // op_in is ignored in every later stage and while halted.
    always_comb begin
        opcode_d = opcode_q;
        if ((state_q == S_IF) && !halted_q) begin
            opcode_d = op_in;
        end
    end

    always_comb begin
        halted_d = halted_q | set_halt;
    end

    // Saturating retire counter
    always_comb begin
        cnt_d = cnt_q;
        if (retire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State register (reset wins over every other update, including a
    // stage in progress or a MEM wait)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= S_IF;
            opcode_q <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
`ifdef MEM_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state/opcode/halted; the MEM-stage
    // strobes additionally depend on mem_ready.
    // ------------------------------------------------------------------
    always_comb begin
        IRWre     = (state_q == S_IF) && !halted_q;
        PCWre     = retire;
        RegWre    = (state_q == S_WB4) ||
                    (state_q == S_WB5) ||
                    ((state_q == S_ID) && (opcode_q == OP_JAL));
        DataMemRW = (state_q == S_MEM) && (opcode_q == OP_SW) && mem_ready;
        mem_err   = tmo_abort;
    end

    assign state       = state_q;
    assign opcode      = opcode_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
// ----------------------------------------------------------------------------
// Each instruction driven by build() pushes its expected per-cycle output
// record (state + enables + mem_err), the mem_ready value and op_in value to
// drive into queues. step() pops one entry per cycle, drives the inputs on the
// falling edge and compares outputs 1 ns later. Counter, opcode and halt
// models are stepped alongside. A second instance with a 2-bit counter shares
// all stimulus so the saturating counter boundary is reached cheaply.
// ============================================================================
module tb_multicycle_ctrl;

  localparam int CNT_W   = 16;
  localparam int SAT_W   = 2;
  localparam int TIMEOUT = 8;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000010;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;

  localparam logic [2:0] ST_IF   = 3'b000;
  localparam logic [2:0] ST_ID   = 3'b001;
  localparam logic [2:0] ST_EXE3 = 3'b101;
  localparam logic [2:0] ST_EXE4 = 3'b110;
  localparam logic [2:0] ST_EXE5 = 3'b010;
  localparam logic [2:0] ST_MEM  = 3'b011;
  localparam logic [2:0] ST_WB4  = 3'b111;
  localparam logic [2:0] ST_WB5  = 3'b100;

  // ---------------- clock / reset ----------------
  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [5:0]       op_in = '0;
  logic             mem_ready = 1'b0;

  always #5 CLK = ~CLK;

  // ---------------- DUT outputs ----------------
  logic [2:0]       state;
  logic [5:0]       opcode;
  logic             PCWre, IRWre, RegWre, DataMemRW, halted, mem_err;
  logic [CNT_W-1:0] instr_count;

  logic [2:0]       s_state;
  logic [5:0]       s_opcode;
  logic             s_PCWre, s_IRWre, s_RegWre, s_DataMemRW, s_halted, s_mem_err;
  logic [SAT_W-1:0] s_count;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_dut (
    .CLK(CLK), .RST(RST), .op_in(op_in), .mem_ready(mem_ready),
    .state(state), .opcode(opcode), .PCWre(PCWre), .IRWre(IRWre),
    .RegWre(RegWre), .DataMemRW(DataMemRW), .halted(halted),
    .mem_err(mem_err), .instr_count(instr_count)
  );

  multicycle_ctrl #(.CNT_W(SAT_W), .TIMEOUT(TIMEOUT)) u_sat (
    .CLK(CLK), .RST(RST), .op_in(op_in), .mem_ready(mem_ready),
    .state(s_state), .opcode(s_opcode), .PCWre(s_PCWre), .IRWre(s_IRWre),
    .RegWre(s_RegWre), .DataMemRW(s_DataMemRW), .halted(s_halted),
    .mem_err(s_mem_err), .instr_count(s_count)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];   // {state, PCWre, IRWre, RegWre, DataMemRW, mem_err}
  logic       rdy_q[$];
  logic [5:0] op_q[$];

  int         exp_count;
  logic [5:0] exp_opc;
  logic       exp_halted;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] mk(input logic [2:0] st, input logic pc, input logic ir,
                                    input logic rw, input logic dm, input logic me);
    return {st, pc, ir, rw, dm, me};
  endfunction

  task automatic push(input logic [7:0] rec, input logic rdy, input logic [5:0] op);
    exp_q.push_back(rec);
    rdy_q.push_back(rdy);
    op_q.push_back(op);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  // Expected trace of one instruction; op_in is only meaningful in IF and
  // mem_ready only in MEM, so both get random values elsewhere.
  task automatic build(input logic [5:0] op, input int waits);
    push(mk(ST_IF, 0, 1, 0, 0, 0), rnd_bit(), op);
    case (op)
      OP_J, OP_JR, OP_HALT: push(mk(ST_ID, 1, 0, 0, 0, 0), rnd_bit(), rnd_op());
      OP_JAL:               push(mk(ST_ID, 1, 0, 1, 0, 0), rnd_bit(), rnd_op());
      OP_BEQ: begin
        push(mk(ST_ID,   0, 0, 0, 0, 0), rnd_bit(), rnd_op());
        push(mk(ST_EXE3, 1, 0, 0, 0, 0), rnd_bit(), rnd_op());
      end
      OP_SW, OP_LW: begin
        push(mk(ST_ID,   0, 0, 0, 0, 0), rnd_bit(), rnd_op());
        push(mk(ST_EXE5, 0, 0, 0, 0, 0), rnd_bit(), rnd_op());
        for (int i = 0; i < waits; i++) push(mk(ST_MEM, 0, 0, 0, 0, 0), 1'b0, rnd_op());
        if (op == OP_LW) begin
          push(mk(ST_MEM, 0, 0, 0, 0, 0), 1'b1, rnd_op());
          push(mk(ST_WB5, 1, 0, 1, 0, 0), rnd_bit(), rnd_op());
        end else begin
          push(mk(ST_MEM, 1, 0, 0, 1, 0), 1'b1, rnd_op());
        end
      end
      default: begin
        push(mk(ST_ID,   0, 0, 0, 0, 0), rnd_bit(), rnd_op());
        push(mk(ST_EXE4, 0, 0, 0, 0, 0), rnd_bit(), rnd_op());
        push(mk(ST_WB4,  1, 0, 1, 0, 0), rnd_bit(), rnd_op());
      end
    endcase
  endtask

  // One clock cycle: drive on negedge, compare 1 ns later, advance models.
  task automatic step();
    logic [7:0] rec;
    logic       r;
    logic [5:0] o;
    int         exp_sat;
    rec = exp_q.pop_front();
    r   = rdy_q.pop_front();
    o   = op_q.pop_front();
    @(negedge CLK);
    op_in     = o;
    mem_ready = r;
    #1;
    exp_sat = (exp_count > SAT_MAX) ? SAT_MAX : exp_count;
    check_eq("trace",     {24'd0, state, PCWre, IRWre, RegWre, DataMemRW, mem_err}, {24'd0, rec});
    check_eq("opcode",    {26'd0, opcode}, {26'd0, exp_opc});
    check_eq("count",     {16'd0, instr_count}, exp_count);
    check_eq("sat_count", {30'd0, s_count}, exp_sat);
    check_eq("halted",    {31'd0, halted}, {31'd0, exp_halted});
    if (rec[7:5] == ST_ID && exp_opc == OP_HALT) exp_halted = 1'b1;
    if (rec[3]) exp_opc = o;
    if (rec[4]) exp_count++;
  endtask

  // Run queued cycles; n > 0 stops after n cycles and discards the rest.
  task automatic drain(input int n);
    int k;
    k = 0;
    while (exp_q.size() > 0 && (n == 0 || k < n)) begin
      step();
      k++;
    end
    exp_q.delete();
    rdy_q.delete();
    op_q.delete();
  endtask

  // One rising edge with RST=0, then check the reset state right after it.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST       = 1'b0;
    op_in     = rnd_op();
    mem_ready = rnd_bit();
    @(posedge CLK);
    #1;
    RST        = 1'b1;
    exp_count  = 0;
    exp_opc    = '0;
    exp_halted = 1'b0;
    check_eq({tag, "_state"},   {29'd0, state}, 32'd0);
    check_eq({tag, "_opcode"},  {26'd0, opcode}, 32'd0);
    check_eq({tag, "_count"},   {16'd0, instr_count}, 32'd0);
    check_eq({tag, "_sat"},     {30'd0, s_count}, 32'd0);
    check_eq({tag, "_halted"},  {31'd0, halted}, 32'd0);
    check_eq({tag, "_mem_err"}, {31'd0, mem_err}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] ops[8] = '{OP_ADD, OP_OR, OP_BEQ, OP_SW, OP_LW, OP_J, OP_JR, OP_JAL};

  initial begin
    exp_count  = 0;
    exp_opc    = '0;
    exp_halted = 1'b0;

    do_reset("rst0");

    // reset in the middle of an R-type (IF, ID, EXE4, then reset)
    build(OP_ADD, 0);
    drain(3);
    do_reset("rst_exe4");

    // directed sequences
    build(OP_ADD, 0); drain(0);
    build(OP_LW, 3);  drain(0);
    do_reset("rst_sw");
    build(OP_SW, 2);  drain(0);
    build(OP_BEQ, 0); drain(0);
    build(OP_SW, 0);  drain(0);

    // random mix, short MEM waits
    for (int i = 0; i < 16; i++) begin
      build(ops[$urandom_range(0, 7)], $urandom_range(0, 5));
      drain(0);
    end

    // reset during a MEM wait (IF, ID, EXE5, MEM, MEM)
    build(OP_LW, 6);
    drain(5);
    do_reset("rst_mem");

`ifdef MEM_TIMEOUT_EN
    // lw never acknowledged: abort on the TIMEOUT-th waiting cycle
    push(mk(ST_IF,   0, 1, 0, 0, 0), 1'b0, OP_LW);
    push(mk(ST_ID,   0, 0, 0, 0, 0), 1'b0, rnd_op());
    push(mk(ST_EXE5, 0, 0, 0, 0, 0), 1'b0, rnd_op());
    for (int i = 0; i < TIMEOUT - 1; i++) push(mk(ST_MEM, 0, 0, 0, 0, 0), 1'b0, rnd_op());
    push(mk(ST_MEM, 0, 0, 0, 0, 1), 1'b0, rnd_op());
    drain(0);
    build(OP_ADD, 0); drain(0);
    // counter restarts for the next access
    build(OP_LW, TIMEOUT - 1); drain(0);
`else
    // without the timeout the core simply keeps waiting
    build(OP_LW, 20); drain(0);
`endif

    // jal then halt, then a parked core ignoring op_in and mem_ready
    build(OP_JAL, 0);  drain(0);
    build(OP_HALT, 0); drain(0);
    for (int i = 0; i < 20; i++) push(mk(ST_IF, 0, 0, 0, 0, 0), rnd_bit(), ops[$urandom_range(0, 7)]);
    drain(0);

    // reset clears the halt and the core runs again
    do_reset("rst_halt");
    build(OP_ADD, 0); drain(0);
    build(OP_J, 0);   drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Sequential control core of the multicycle CPU. It owns the 3-bit state register and the instruction-opcode register, and computes the successor state from the team's fixed stage encoding. It drives the per-state datapath write enables to the PC, IR, register file and data memory. It also provides a sticky halt flag, a MEM-stage wait handshake and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)
TIMEOUT, 8, max MEM wait cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous active-low reset, sampled on rising CLK
op_in  in  6  opcode from instruction memory, valid during IF
mem_ready  in  1  data memory completion, sampled only in MEM
state  out  3  current stage encoding
opcode  out  6  latched opcode (IR[31:26])
PCWre  out  1  PC write enable
IRWre  out  1  instruction register write enable
RegWre  out  1  register file write enable
DataMemRW  out  1  1 = data memory write (sw), 0 = read
halted  out  1  sticky halt indication
mem_err  out  1  MEM timeout pulse (MEM_TIMEOUT_EN only, else tied 0)
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- State encoding (fixed): IF=000, ID=001, EXE3=101, EXE4=110, EXE5=010, MEM=011, WB4=111, WB5=100.
- Reset (RST=0 at a rising edge) has priority over everything, including mid-instruction and MEM wait:
  - state=IF, opcode=000000, halted=0, instr_count=0, mem_err=0, timeout counter=0.
- IF: opcode <= op_in; IRWre=1; next state ID.
- ID, by opcode:
  - j 111000, jal 111010, jr 111001 -> IF; instruction retires here.
  - halt 111111 -> IF with halted <= 1; retires.
  - beq 110100 -> EXE3.
  - sw 110000, lw 110001 -> EXE5.
  - all others -> EXE4.
- EXE3 -> IF (retire). EXE4 -> WB4. EXE5 -> MEM.
- MEM:
  - Stays in MEM while mem_ready=0.
  - When mem_ready=1: lw -> WB5; sw -> IF (retire).
- WB4 -> IF (retire). WB5 -> IF (retire). Undefined encodings -> IF, no retire.
- Retire = the cycle whose transition returns to IF with halted=0 before the edge.
  - PCWre=1 in exactly that cycle.
  - instr_count increments by 1 on that edge; saturates at all-ones and holds.
- RegWre=1 in WB4, in WB5, and in ID when opcode=jal. 0 otherwise.
- DataMemRW=1 only in MEM with opcode=sw and mem_ready=1 (single write strobe). 0 otherwise.
- Outputs are combinational from registered state/opcode/halted plus mem_ready (Mealy in MEM only).
- Halt:
  - The halt instruction itself retires (PCWre=1, count+1) on its ID cycle.
  - Afterwards halted=1 and state holds at IF.
  - IRWre=0, PCWre=0, RegWre=0, DataMemRW=0, counter frozen, op_in ignored, until reset.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined: an internal counter counts consecutive MEM cycles with mem_ready=0.
  - When the count reaches TIMEOUT (the TIMEOUT-th waiting cycle), mem_err=1 for that cycle and next state is IF.
  - The instruction does not retire (PCWre=0, no count, no write).
  - The counter clears on leaving MEM or on reset.
- Undefined: no counter; mem_err constant 0; MEM waits indefinitely.

Test Plan:
- Reset mid-EXE4 (RST=0 one edge) -> state=000, opcode=0, instr_count=0, halted=0 next cycle.
- add (000000) with mem_ready=1 -> states 000,001,110,111,000. RegWre=1 only in 111. PCWre=1 in 111. instr_count 0->1.
- lw (110001), mem_ready low for 3 MEM cycles then high -> states 000,001,010,011,011,011,011,100,000. DataMemRW=0 throughout. RegWre=1 in 100.
- sw then beq -> sw: DataMemRW=1 in the single MEM cycle with mem_ready=1, then IF. beq: 000,001,101,000 with PCWre=1 in 101. instr_count=2.
- jal then halt -> jal: RegWre=1 and PCWre=1 in ID, then IF. halt: PCWre=1 in ID, then halted=1. 20 further cycles at IF with all enables 0 and instr_count=2.
- MEM_TIMEOUT_EN, TIMEOUT=8, lw with mem_ready held 0 -> mem_err=1 on the 8th MEM cycle, next state 000, instr_count unchanged. Without the macro the state stays 011.
